// File: rtl/axi_csr_if.sv
// AXI4 slave front-end bridging single-beat reads/writes onto a simple CSR bus.
// One transaction in flight; round-robin between AW and AR on simultaneous requests.
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | arbitrate AW/AR, latch address and ID on the granted handshake
// WR_DATA | wait for W (wready follows csr_resp_ready), issue CSR write
// WR_RESP | bvalid held until bready
// RD_REQ  | issue CSR read once csr_resp_ready (skipped if unaligned)
// RD_CAPT | register CSR read data/error
// RD_RESP | rvalid held until rready
module axi_csr_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int ID_WIDTH   = 1
) (
  input  logic                  clk_axi,
  input  logic                  arst_axi,
  input  logic                  awvalid,
  output logic                  awready,
  input  logic [ADDR_WIDTH-1:0] awaddr,
  input  logic [ID_WIDTH-1:0]   awid,
  input  logic                  wvalid,
  output logic                  wready,
  input  logic [31:0]           wdata,
  output logic                  bvalid,
  input  logic                  bready,
  output logic [1:0]            bresp,
  output logic [ID_WIDTH-1:0]   bid,
  input  logic                  arvalid,
  output logic                  arready,
  input  logic [ADDR_WIDTH-1:0] araddr,
  input  logic [ID_WIDTH-1:0]   arid,
  output logic                  rvalid,
  input  logic                  rready,
  output logic [31:0]           rdata,
  output logic [1:0]            rresp,
  output logic [ID_WIDTH-1:0]   rid,
  output logic                  rlast,
  output logic                  csr_req_valid,
  output logic                  csr_req_rd_or_wr,
  output logic [ADDR_WIDTH-1:0] csr_req_addr,
  output logic [31:0]           csr_req_data_in,
  input  logic                  csr_resp_ready,
  input  logic                  csr_resp_error,
  input  logic [31:0]           csr_resp_data_out
);

  typedef enum logic [2:0] {
    IDLE, WR_DATA, WR_RESP, RD_REQ, RD_CAPT, RD_RESP
  } state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  state_t                state_q, state_d;
  logic                  prio_wr_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [ID_WIDTH-1:0]   bid_q, rid_q;
  logic [1:0]            bresp_q, rresp_q;
  logic [31:0]           rdata_q;
  logic                  grant_wr, grant_rd, aligned, w_hs;

  assign aligned  = (addr_q[1:0] == 2'b00);
  assign grant_wr = awvalid && (!arvalid || prio_wr_q);
  assign grant_rd = arvalid && (!awvalid || !prio_wr_q);
  assign w_hs     = (state_q == WR_DATA) && wvalid && csr_resp_ready;

  always_comb begin
    state_d          = state_q;
    awready          = 1'b0;
    arready          = 1'b0;
    wready           = 1'b0;
    bvalid           = 1'b0;
    rvalid           = 1'b0;
    csr_req_valid    = 1'b0;
    csr_req_rd_or_wr = 1'b0;
    csr_req_data_in  = '0;
    case (state_q)
      IDLE: begin
        // Readies are gated by reset so nothing is accepted while held in reset.
        awready = grant_wr && !arst_axi;
        arready = grant_rd && !arst_axi;
        if (grant_wr)      state_d = WR_DATA;
        else if (grant_rd) state_d = RD_REQ;
      end
      WR_DATA: begin
        wready = csr_resp_ready;
        if (w_hs) begin
          csr_req_valid    = aligned;
          csr_req_rd_or_wr = aligned;
          csr_req_data_in  = aligned ? wdata : '0;
          state_d          = WR_RESP;
        end
      end
      WR_RESP: begin
        bvalid = 1'b1;
        if (bready) state_d = IDLE;
      end
      RD_REQ: begin
        if (!aligned) begin
          state_d = RD_CAPT;
        end else if (csr_resp_ready) begin
          csr_req_valid = 1'b1;
          state_d       = RD_CAPT;
        end
      end
      RD_CAPT: state_d = RD_RESP;
      RD_RESP: begin
        rvalid = 1'b1;
        if (rready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_axi or posedge arst_axi) begin
    if (arst_axi) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_ff @(posedge clk_axi or posedge arst_axi) begin
    if (arst_axi) begin
      prio_wr_q <= 1'b1;
      addr_q    <= '0;
      bid_q     <= '0;
      rid_q     <= '0;
      bresp_q   <= RESP_OKAY;
      rresp_q   <= RESP_OKAY;
      rdata_q   <= '0;
    end else begin
      if (awready) begin
        addr_q    <= awaddr;
        bid_q     <= awid;
        prio_wr_q <= 1'b0;
      end else if (arready) begin
        addr_q    <= araddr;
        rid_q     <= arid;
        prio_wr_q <= 1'b1;
      end
      if (w_hs)
        bresp_q <= (!aligned || csr_resp_error) ? RESP_SLVERR : RESP_OKAY;
      if (state_q == RD_CAPT) begin
        rdata_q <= aligned ? csr_resp_data_out : '0;
        rresp_q <= (!aligned || csr_resp_error) ? RESP_SLVERR : RESP_OKAY;
      end
    end
  end

  assign bresp        = bresp_q;
  assign bid          = bid_q;
  assign rdata        = rdata_q;
  assign rresp        = rresp_q;
  assign rid          = rid_q;
  assign rlast        = 1'b1;
  assign csr_req_addr = addr_q;

endmodule

// File: tb/tb_axi_csr_if.sv
// Randomized scoreboard bench for axi_csr_if: an AXI master driver, a CSR slave
// model, and a register-map reference model feeding expected responses to a monitor.
module tb_axi_csr_if;
  localparam int AW = 32;
  localparam int IW = 1;

  logic          clk_axi = 1'b0;
  logic          arst_axi;
  logic          awvalid, awready, wvalid, wready, bvalid, bready;
  logic [AW-1:0] awaddr, araddr;
  logic [IW-1:0] awid, arid, bid, rid;
  logic [31:0]   wdata, rdata;
  logic [1:0]    bresp, rresp;
  logic          arvalid, arready, rvalid, rready, rlast;
  logic          csr_req_valid, csr_req_rd_or_wr;
  logic [AW-1:0] csr_req_addr;
  logic [31:0]   csr_req_data_in;
  logic          csr_resp_ready, csr_resp_error;
  logic [31:0]   csr_resp_data_out;

  always #5 clk_axi = ~clk_axi;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  always @(posedge clk_axi) cyc <= cyc + 1;

  axi_csr_if #(.ADDR_WIDTH(AW), .ID_WIDTH(IW)) dut (
    .clk_axi(clk_axi), .arst_axi(arst_axi),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awid(awid),
    .wvalid(wvalid), .wready(wready), .wdata(wdata),
    .bvalid(bvalid), .bready(bready), .bresp(bresp), .bid(bid),
    .arvalid(arvalid), .arready(arready), .araddr(araddr), .arid(arid),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp), .rid(rid), .rlast(rlast),
    .csr_req_valid(csr_req_valid), .csr_req_rd_or_wr(csr_req_rd_or_wr),
    .csr_req_addr(csr_req_addr), .csr_req_data_in(csr_req_data_in),
    .csr_resp_ready(csr_resp_ready), .csr_resp_error(csr_resp_error),
    .csr_resp_data_out(csr_resp_data_out)
  );

  // CSR slave: 16 words at 0x00-0x3C, addresses 0x30-0x3F answer with an error.
  function automatic logic is_err(logic [31:0] a);
    return a[5:4] == 2'b11;
  endfunction
  function automatic logic [31:0] init_val(int i);
    return 32'h5A00_0000 + 32'(i) * 32'h0000_0101;
  endfunction

  logic [31:0] slv_mem [0:15];
  logic        rd_err_q;
  logic [31:0] rd_data_q;
  assign csr_resp_error    = (csr_req_valid && csr_req_rd_or_wr) ? is_err(csr_req_addr) : rd_err_q;
  assign csr_resp_data_out = rd_data_q;

  always @(posedge clk_axi or posedge arst_axi) begin
    if (arst_axi) begin
      rd_err_q  <= 1'b0;
      rd_data_q <= 32'h0;
      for (int i = 0; i < 16; i++) slv_mem[i] <= init_val(i);
    end else begin
      rd_err_q  <= csr_req_valid && !csr_req_rd_or_wr && is_err(csr_req_addr);
      // Junk outside the capture cycle exposes a mistimed capture.
      rd_data_q <= (csr_req_valid && !csr_req_rd_or_wr) ? slv_mem[csr_req_addr[5:2]] : $urandom;
      if (csr_req_valid && csr_req_rd_or_wr && !is_err(csr_req_addr))
        slv_mem[csr_req_addr[5:2]] <= csr_req_data_in;
    end
  end

  bit rdy_rand = 1'b0;
  initial begin
    csr_resp_ready = 1'b1;
    forever begin
      @(posedge clk_axi); #1;
      csr_resp_ready = rdy_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
  end

  // Reference model: register map plus expectation queues.
  typedef struct packed {logic wr; logic [1:0] resp; logic [31:0] data; logic [IW-1:0] id;} rsp_t;
  typedef struct packed {logic wr; logic [31:0] addr; logic [31:0] data;} req_t;
  logic [31:0] mdl_mem [0:15];
  rsp_t rsp_q[$];
  req_t req_q[$];
  bit   grant_log[$];
  bit   tb_prio_wr;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic fail(input string nm, input string act, input string exp);
    n_cmp++;
    n_err++;
    $display("FAIL %s: got %s expected %s at %0t", nm, act, exp, $time);
  endtask

  task automatic mdl_write(input logic [31:0] a, input logic [31:0] d, input logic [IW-1:0] id,
                           output logic [1:0] resp);
    rsp_t r;
    req_t q;
    bit ok;
    ok   = (a[1:0] == 2'b00);
    resp = (ok && !is_err(a)) ? 2'b00 : 2'b10;
    if (ok) begin
      q.wr = 1'b1; q.addr = a; q.data = d;
      req_q.push_back(q);
      if (!is_err(a)) mdl_mem[a[5:2]] = d;
    end
    r.wr = 1'b1; r.resp = resp; r.data = 32'h0; r.id = id;
    rsp_q.push_back(r);
    grant_log.push_back(1'b1);
    tb_prio_wr = 1'b0;
  endtask

  task automatic mdl_read(input logic [31:0] a, input logic [IW-1:0] id,
                          output logic [1:0] resp, output logic [31:0] data);
    rsp_t r;
    req_t q;
    bit ok;
    ok   = (a[1:0] == 2'b00);
    resp = (ok && !is_err(a)) ? 2'b00 : 2'b10;
    data = ok ? mdl_mem[a[5:2]] : 32'h0;
    if (ok) begin
      q.wr = 1'b0; q.addr = a; q.data = 32'h0;
      req_q.push_back(q);
    end
    r.wr = 1'b0; r.resp = resp; r.data = data; r.id = id;
    rsp_q.push_back(r);
    grant_log.push_back(1'b0);
    tb_prio_wr = 1'b1;
  endtask

  task automatic monitor();
    req_t q;
    rsp_t r;
    forever begin
      @(negedge clk_axi);
      if (!arst_axi) begin
        if (csr_req_valid) begin
          if (req_q.size() == 0) fail("csr_req_unexpected", "pulse", "none");
          else begin
            q = req_q.pop_front();
            chk("csr_rd_or_wr", 32'(csr_req_rd_or_wr), 32'(q.wr));
            chk("csr_addr", csr_req_addr, q.addr);
            if (q.wr) chk("csr_data", csr_req_data_in, q.data);
          end
        end
        if (bvalid && bready) begin
          if (rsp_q.size() == 0) fail("b_unexpected", "bvalid", "none");
          else begin
            r = rsp_q.pop_front();
            chk("b_order", 32'(r.wr), 32'd1);
            chk("bresp", 32'(bresp), 32'(r.resp));
            chk("bid", 32'(bid), 32'(r.id));
          end
        end
        if (rvalid && rready) begin
          if (rsp_q.size() == 0) fail("r_unexpected", "rvalid", "none");
          else begin
            r = rsp_q.pop_front();
            chk("r_order", 32'(r.wr), 32'd0);
            chk("rdata", rdata, r.data);
            chk("rresp", 32'(rresp), 32'(r.resp));
            chk("rid", 32'(rid), 32'(r.id));
            chk("rlast", 32'(rlast), 32'd1);
          end
        end
      end
    end
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [IW-1:0] id,
                          input int bdel, output int lat);
    logic [1:0] er;
    int k, c0;
    bit early;
    lat   = -1;
    early = ($urandom_range(0, 1) == 1);
    @(posedge clk_axi); #1;
    awvalid = 1'b1; awaddr = a; awid = id; wdata = d; wvalid = early;
    k = 0;
    do begin @(negedge clk_axi); k++; end while (!awready && k < 200);
    if (!awready) begin
      fail("aw_timeout", "no handshake", "handshake");
      awvalid = 1'b0; wvalid = 1'b0;
      return;
    end
    if (early) chk("w_before_aw", 32'(wready), 32'd0);
    c0 = cyc;
    mdl_write(a, d, id, er);
    @(posedge clk_axi); #1;
    awvalid = 1'b0; wvalid = 1'b1;
    k = 0;
    do begin @(negedge clk_axi); k++; end while (!wready && k < 200);
    @(posedge clk_axi); #1;
    wvalid = 1'b0;
    if (k >= 200) begin fail("w_timeout", "no handshake", "handshake"); return; end
    k = 0;
    do begin @(negedge clk_axi); k++; end while (!bvalid && k < 200);
    if (!bvalid) begin fail("b_timeout", "no bvalid", "bvalid"); return; end
    lat = cyc - c0;
    repeat (bdel) begin
      @(posedge clk_axi); #1;
      @(negedge clk_axi);
      chk("bvalid_hold", 32'(bvalid), 32'd1);
      chk("bresp_hold", 32'(bresp), 32'(er));
    end
    @(posedge clk_axi); #1;
    bready = 1'b1;
    @(negedge clk_axi);
    @(posedge clk_axi); #1;
    bready = 1'b0;
  endtask

  task automatic do_read(input logic [31:0] a, input logic [IW-1:0] id, input int rdel,
                         input bit abort_rst, output int lat);
    logic [1:0]  er;
    logic [31:0] ed;
    int k, c0;
    lat = -1;
    @(posedge clk_axi); #1;
    arvalid = 1'b1; araddr = a; arid = id;
    k = 0;
    do begin @(negedge clk_axi); k++; end while (!arready && k < 200);
    if (!arready) begin
      fail("ar_timeout", "no handshake", "handshake");
      arvalid = 1'b0;
      return;
    end
    c0 = cyc;
    mdl_read(a, id, er, ed);
    @(posedge clk_axi); #1;
    arvalid = 1'b0;
    k = 0;
    do begin @(negedge clk_axi); k++; end while (!rvalid && k < 200);
    if (!rvalid) begin fail("r_timeout", "no rvalid", "rvalid"); return; end
    lat = cyc - c0;
    if (abort_rst) begin
      #2 arst_axi = 1'b1;
      #1 chk("rvalid_drop_on_reset", 32'(rvalid), 32'd0);
      return;
    end
    repeat (rdel) begin
      @(posedge clk_axi); #1;
      @(negedge clk_axi);
      chk("rvalid_hold", 32'(rvalid), 32'd1);
      chk("rresp_hold", 32'(rresp), 32'(er));
      chk("rdata_hold", rdata, ed);
    end
    @(posedge clk_axi); #1;
    rready = 1'b1;
    @(negedge clk_axi);
    @(posedge clk_axi); #1;
    rready = 1'b0;
  endtask

  function automatic logic [31:0] rnd_addr();
    logic [31:0] a;
    a = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
    if ($urandom_range(0, 3) == 0) a[1:0] = 2'($urandom_range(1, 3));
    return a;
  endfunction

  task automatic pair(input logic [31:0] wa, input logic [31:0] wd, input logic [31:0] ra);
    int lw, lr;
    bit exp_first;
    exp_first = tb_prio_wr;
    grant_log.delete();
    fork
      do_write(wa, wd, 1'b1, 0, lw);
      do_read(ra, 1'b0, 0, 1'b0, lr);
    join
    chk("arb_grants", 32'(grant_log.size()), 32'd2);
    if (grant_log.size() == 2) chk("arb_first_grant_wr", 32'(grant_log[0]), 32'(exp_first));
  endtask

  initial begin
    int lat;
    arst_axi = 1'b1;
    awvalid = 1'b1; arvalid = 1'b1; wvalid = 1'b1;
    awaddr = 32'h0; araddr = 32'h0; awid = '0; arid = '0; wdata = 32'h0;
    bready = 1'b0; rready = 1'b0;
    tb_prio_wr = 1'b1;
    for (int i = 0; i < 16; i++) mdl_mem[i] = init_val(i);
    fork monitor(); join_none

    repeat (3) @(posedge clk_axi);
    #1;
    chk("rst_awready", 32'(awready), 32'd0);
    chk("rst_arready", 32'(arready), 32'd0);
    chk("rst_wready", 32'(wready), 32'd0);
    chk("rst_bvalid", 32'(bvalid), 32'd0);
    chk("rst_rvalid", 32'(rvalid), 32'd0);
    chk("rst_csr_req_valid", 32'(csr_req_valid), 32'd0);
    chk("rst_csr_rd_or_wr", 32'(csr_req_rd_or_wr), 32'd0);
    chk("rst_csr_addr", csr_req_addr, 32'd0);
    chk("rst_csr_data", csr_req_data_in, 32'd0);
    chk("rst_bresp", 32'(bresp), 32'd0);
    chk("rst_rresp", 32'(rresp), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_bid", 32'(bid), 32'd0);
    chk("rst_rid", 32'(rid), 32'd0);
    chk("rst_rlast", 32'(rlast), 32'd1);
    @(negedge clk_axi);
    arst_axi = 1'b0; awvalid = 1'b0; arvalid = 1'b0; wvalid = 1'b0;

    // Simultaneous AW/AR right after reset: write first, then read.
    pair(32'h20, 32'h1234_5678, 32'h20);

    do_write(32'h10, 32'h5, 1'b0, 0, lat);
    chk("wr_latency", 32'(lat), 32'd2);

    // Priority now sits with the read channel.
    pair(32'h24, 32'hA5A5_0F0F, 32'h10);

    do_write(32'h0, 32'hCAFE_0001, 1'b0, 0, lat);
    do_read(32'h0, 1'b1, 0, 1'b0, lat);
    chk("rd_latency", 32'(lat), 32'd3);

    do_read(32'h30, 1'b0, 5, 1'b0, lat);
    do_write(32'h13, 32'hDEAD_0013, 1'b1, 2, lat);
    do_read(32'h13, 1'b1, 1, 1'b0, lat);

    rdy_rand = 1'b1;
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 5) == 0)
        pair(rnd_addr(), $urandom, rnd_addr());
      else if ($urandom_range(0, 1) == 0)
        do_write(rnd_addr(), $urandom, 1'($urandom_range(0, 1)), $urandom_range(0, 3), lat);
      else
        do_read(rnd_addr(), 1'($urandom_range(0, 1)), $urandom_range(0, 3), 1'b0, lat);
    end
    rdy_rand = 1'b0;

    // Reset while a read response is pending.
    do_write(32'h4, 32'h0BAD_F00D, 1'b0, 0, lat);
    do_read(32'h4, 1'b1, 0, 1'b1, lat);
    repeat (2) @(posedge clk_axi);
    #1;
    chk("rst_mid_rvalid", 32'(rvalid), 32'd0);
    chk("rst_mid_bvalid", 32'(bvalid), 32'd0);
    @(negedge clk_axi);
    rsp_q.delete();
    req_q.delete();
    for (int i = 0; i < 16; i++) mdl_mem[i] = init_val(i);
    tb_prio_wr = 1'b1;
    arst_axi = 1'b0;
    do_write(32'h8, 32'hDEAD_BEEF, 1'b1, 1, lat);
    chk("post_rst_wr_latency", 32'(lat), 32'd2);
    do_read(32'h8, 1'b0, 0, 1'b0, lat);

    repeat (5) @(negedge clk_axi);
    chk("scoreboard_drained", 32'(rsp_q.size() + req_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no end of test expected end before 500000");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/axi_csr_if.md
AXI_CSR_IF -- requirements
Module: axi_csr_if

Interface
Parameters
REQ-001 ADDR_WIDTH, 32, width of AXI and CSR address.
REQ-002 ID_WIDTH, 1, width of AXI transaction IDs; IDs are echoed, not interpreted.

Ports
REQ-003 clk_axi  in  1  clock; all logic on the rising edge.
REQ-004 arst_axi  in  1  reset; asynchronous, active-high.
REQ-005 awvalid/awready  in/out  1/1  AXI write-address handshake.
REQ-006 awaddr/awid  in  ADDR_WIDTH/ID_WIDTH  write address and ID.
REQ-007 wvalid/wready  in/out  1/1  write-data handshake.
REQ-008 wdata  in  32  write data; byte strobes are not supported, and full-word writes only.
REQ-009 bvalid/bready  out/in  1/1  write-response handshake.
REQ-010 bresp/bid  out  2/ID_WIDTH  write response (OKAY=00, SLVERR=10) and echoed ID.
REQ-011 arvalid/arready  in/out  1/1  read-address handshake.
REQ-012 araddr/arid  in  ADDR_WIDTH/ID_WIDTH  read address and ID.
REQ-013 rvalid/rready  out/in  1/1  read-data handshake.
REQ-014 rdata/rresp/rid/rlast  out  32/2/ID_WIDTH/1  read data, response, echoed ID and last flag; rlast is constant 1.
REQ-015 csr_req_valid/csr_req_rd_or_wr  out  1/1  CSR request strobe; rd_or_wr is 1 for write and 0 for read.
REQ-016 csr_req_addr/csr_req_data_in  out  ADDR_WIDTH/32  CSR address and write data.
REQ-017 csr_resp_ready/csr_resp_error/csr_resp_data_out  in  1/1/32  CSR response.
- Write error is combinational in the request cycle.
- Read error and read data are valid exactly one cycle after the request cycle.

Function
REQ-018 The FSM SHALL have the states IDLE, WR_DATA, WR_RESP, RD_REQ, RD_CAPT and RD_RESP; only one transaction SHALL be in flight at a time.
REQ-019 In IDLE, awready and arready SHALL be driven combinationally from arbitration; no other state SHALL assert either signal.
REQ-020 Arbitration SHALL be round-robin on simultaneous awvalid and arvalid.
- Write has priority after reset.
- After a grant, priority passes to the other channel.
REQ-021 On an AW handshake, the block SHALL latch awaddr and awid and go to WR_DATA.
REQ-022 On an AR handshake, the block SHALL latch araddr and arid and go to RD_REQ.
REQ-023 In WR_DATA, wready SHALL equal csr_resp_ready.
REQ-024 On a W handshake with an aligned address, the block SHALL assert csr_req_valid=1 and rd_or_wr=1 in the same cycle, with the latched address and wdata.
- bresp SHALL be latched as SLVERR if csr_resp_error=1, else OKAY.
- The next state SHALL be WR_RESP.
REQ-025 In RD_REQ, while csr_resp_ready=1, the block SHALL assert csr_req_valid=1 and rd_or_wr=0 for exactly one cycle, then go to RD_CAPT; while csr_resp_ready=0, it SHALL hold in RD_REQ.
REQ-026 In RD_CAPT, the block SHALL register csr_resp_data_out into rdata and csr_resp_error into rresp (SLVERR or OKAY), then go to RD_RESP.
REQ-027 In WR_RESP, bvalid SHALL be 1 and held until bready; on the handshake the state SHALL return to IDLE.
REQ-028 In RD_RESP, rvalid SHALL be 1 and held until rready; on the handshake the state SHALL return to IDLE.
REQ-029 bresp, bid, rdata, rresp and rid SHALL remain stable while their valid signal is high.
REQ-030 For an unaligned address (addr[1:0]!=0), no CSR request SHALL be issued.
- Write: respond SLVERR.
- Read: respond rdata=0, SLVERR.
REQ-031 Minimum latencies SHALL be as follows.
- Write: AW in cycle N, W in cycle N+1, bvalid in cycle N+2.
- Read: AR in cycle N, CSR request in N+1, capture in N+2, rvalid in N+3.
REQ-032 csr_req_valid SHALL be 0 in every state and cycle not listed in REQ-024 and REQ-025.
REQ-033 wvalid arriving before the AW handshake SHALL NOT be accepted (wready=0 outside WR_DATA).

Reset
REQ-034 While arst_axi=1, the block SHALL hold the following.
- State is IDLE and round-robin priority is write.
- All ready, valid and csr_req_* outputs are 0.
- bresp, rresp, rdata, bid and rid are 0; rlast is 1.
REQ-035 Reset asserted mid-transaction SHALL abort the transaction with no response, and the block SHALL return to IDLE.

Verification
REQ-036 Write 0x5 to address 0x10 with the error input low -> one csr_req_valid pulse with rd_or_wr=1, data 0x5 and addr 0x10, then bresp=00.
REQ-037 Read address 0x0 with the CSR returning data 0xCAFE0001 and error 0 one cycle later -> rdata=0xCAFE0001, rresp=00, rid equal to arid, rlast=1.
REQ-038 Read with csr_resp_error pulsed high in the capture cycle only -> rresp=10, and rresp remains 10 with rready held low for 5 cycles.
REQ-039 awvalid and arvalid asserted together for two back-to-back transactions -> the write is granted first, then the read.
REQ-040 Write to address 0x13 -> no csr_req_valid pulse and bresp=10; read from 0x13 -> rdata=0 and rresp=10.
REQ-041 arst_axi pulsed while in RD_RESP -> rvalid drops immediately, and a following write completes normally.
